// File: rtl/gate_op_pkg.sv
// Shared types and constants for the gate-op arbiter: opcodes, FSM states, counter width.
package gate_op_pkg;

    typedef enum logic [1:0] {
        OP_NAND = 2'b00,
        OP_NOR  = 2'b01,
        OP_XOR  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOLD
    } state_t;

    localparam int CNT_W = 8;

endpackage

// File: rtl/gate_unit.sv
// Combinational bitwise gate: NAND/NOR/XOR of two operands, error flag on the reserved opcode.
module gate_unit
    import gate_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        y   = '0;
        err = 1'b0;
        case (op)
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter feeding one shared gate_unit; IDLE -> EXEC -> HOLD per operation.
// Optional per-requester grant counters are built when GATE_OP_ARB_STATS_EN is defined.
module gate_op_arbiter
    import gate_op_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]       req_op,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic                       res_err,
    output logic [NUM_REQ*CNT_W-1:0]   grant_cnt,
    input  logic                       stats_clr
);

    localparam int ID_W = $clog2(NUM_REQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ID_W-1:0]   r_last_grant;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_grant_found;
    logic              w_accept;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    op_t               r_op;
    logic [ID_W-1:0]   r_id;
    logic [WIDTH-1:0]  r_res_data;
    logic [ID_W-1:0]   r_res_id;
    logic              r_res_err;
    logic [WIDTH-1:0]  w_y;
    logic              w_err;

    // Search begins one past the last grant so every requester gets a turn.
    always_comb begin
        w_grant_idx   = '0;
        w_grant_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            automatic int idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_grant_found && req_valid[idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(idx);
            end
        end
    end

    assign w_accept = (r_state == ST_IDLE) && w_grant_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_grant_idx] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_found) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_HOLD;
            ST_HOLD: if (res_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    gate_unit #(.WIDTH(WIDTH)) u_gate_unit (
        .a   (r_a),
        .b   (r_b),
        .op  (r_op),
        .y   (w_y),
        .err (w_err)
    );

    // Operands are frozen at acceptance; later input changes cannot reach the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= OP_NAND;
            r_id         <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_res_data   <= '0;
            r_res_id     <= '0;
            r_res_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= req_a[w_grant_idx*WIDTH +: WIDTH];
                r_b          <= req_b[w_grant_idx*WIDTH +: WIDTH];
                r_op         <= op_t'(req_op[w_grant_idx*2 +: 2]);
                r_id         <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == ST_EXEC) begin
                r_res_data <= w_y;
                r_res_id   <= r_id;
                r_res_err  <= w_err;
            end
        end
    end

    assign res_valid = (r_state == ST_HOLD);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign res_err   = r_res_err;

`ifdef GATE_OP_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst || stats_clr)
                r_cnt <= '0;
            else if (w_accept && (w_grant_idx == ID_W'(i)) && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt;
    end
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
    assign grant_cnt          = '0;
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter (default and GATE_OP_ARB_STATS_EN builds).
module tb_gate_op_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*2-1:0]     req_op;
    logic                     res_valid;
    logic                     res_ready;
    logic [WIDTH-1:0]         res_data;
    logic [1:0]               res_id;
    logic                     res_err;
    logic [NUM_REQ*8-1:0]     grant_cnt;
    logic                     stats_clr;

    int checks   = 0;
    int failures = 0;

    gate_op_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err),
        .grant_cnt (grant_cnt),
        .stats_clr (stats_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         idx;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b1;
        stats_clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_vec(input vec_t v);
        logic [NUM_REQ-1:0] oh;
        oh = NUM_REQ'(1) << v.idx;
        req_valid              = oh;
        req_a[v.idx*8 +: 8]    = v.a;
        req_b[v.idx*8 +: 8]    = v.b;
        req_op[v.idx*2 +: 2]   = v.op;
        res_ready              = 1'b1;
        #1 check("vec_ready", 64'(req_ready), 64'(oh));
        @(negedge clk);
        req_valid = '0;
        req_a     = ~req_a;
        req_b     = ~req_b;
        req_op    = ~req_op;
        #1 check("vec_exec_valid", 64'(res_valid), 64'd0);
        @(negedge clk);
        #1;
        check("vec_hold_valid", 64'(res_valid), 64'd1);
        check("vec_data", 64'(res_data), 64'(v.exp_data));
        check("vec_id", 64'(res_id), 64'(v.idx));
        check("vec_err", 64'(res_err), 64'(v.exp_err));
        @(negedge clk);
        #1 check("vec_idle_valid", 64'(res_valid), 64'd0);
    endtask

    initial begin
        int g_idx [$];
        int g_cyc [$];
        logic [7:0] held;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        res_ready = 1'b1; stats_clr = 1'b0;

        vecs[0] = '{0, 8'hF0, 8'hCC, 2'b10, 8'h3C, 1'b0};
        vecs[1] = '{2, 8'hAA, 8'h55, 2'b11, 8'h00, 1'b1};
        vecs[2] = '{1, 8'hF0, 8'hCC, 2'b00, 8'h3F, 1'b0};
        vecs[3] = '{3, 8'hF0, 8'hCC, 2'b01, 8'h03, 1'b0};
        vecs[4] = '{2, 8'hA5, 8'h0F, 2'b10, 8'hAA, 1'b0};
        vecs[5] = '{0, 8'h00, 8'h00, 2'b00, 8'hFF, 1'b0};
        vecs[6] = '{3, 8'hFF, 8'h00, 2'b01, 8'h00, 1'b0};

        do_reset();
        #1;
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_res_err", 64'(res_err), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_grant_cnt", 64'(grant_cnt), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Round-robin with everyone asking: grants 0,1,2,3,0 three cycles apart.
        do_reset();
        req_valid = '1; req_a = '1; req_b = '1; req_op = '0; res_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            #1;
            for (int r = 0; r < NUM_REQ; r++)
                if (req_ready[r]) begin g_idx.push_back(r); g_cyc.push_back(c); end
            if (res_valid) check("rr_data", 64'(res_data), 64'h00);
            @(negedge clk);
        end
        req_valid = '0;
        check("rr_count", 64'(g_idx.size()), 64'd5);
        for (int k = 0; k < 5 && k < g_idx.size(); k++) begin
            check("rr_idx", 64'(g_idx[k]), 64'(k % NUM_REQ));
            check("rr_cycle", 64'(g_cyc[k]), 64'(3 * k));
        end

        // Backpressure: HOLD for extra cycles with another requester waiting.
        @(negedge clk);
        req_valid = 4'b0001; req_a[7:0] = 8'hF0; req_b[7:0] = 8'hCC; req_op[1:0] = 2'b10;
        res_ready = 1'b0;
        #1 check("bp_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        held = res_data;
        check("bp_first_data", 64'(held), 64'h3C);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_valid", 64'(res_valid), 64'd1);
            check("bp_data_stable", 64'(res_data), 64'(held));
            check("bp_no_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1 check("bp_release_valid", 64'(res_valid), 64'd1);
        @(negedge clk);
        #1;
        check("bp_idle_valid", 64'(res_valid), 64'd0);
        check("bp_next_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset mid-operation drops the result and restores requester 0 priority.
        req_valid = 4'b0001;
        #1 check("rx_ready", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 check("rx_no_valid", 64'(res_valid), 64'd0);
            @(negedge clk);
        end
        req_valid = 4'b0011;
        #1 check("rx_prio0", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

`ifdef GATE_OP_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0010; res_ready = 1'b1;
        repeat (900) @(negedge clk);
        #1;
        check("cnt_sat", 64'(grant_cnt[15:8]), 64'd255);
        check("cnt_other", 64'(grant_cnt[7:0]), 64'd0);
        stats_clr = 1'b1;
        #1 check("cnt_clr_grant", 64'(req_ready), 64'b0010);
        @(negedge clk);
        stats_clr = 1'b0;
        req_valid = '0;
        #1 check("cnt_cleared", 64'(grant_cnt), 64'd0);
        repeat (3) @(negedge clk);
        #1 check("cnt_one_after", 64'(grant_cnt[15:8]), 64'd0);
`else
        do_reset();
        req_valid = 4'b0010; res_ready = 1'b1;
        repeat (9) @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        req_valid = '0;
        #1 check("cnt_tied0", 64'(grant_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_op_arbiter.md
GATE_OP_ARBITER -- requirements
Module: gate_op_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-003 SHALL have one clock and a synchronous active-high reset, with all state updated on the rising edge of the clock.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous reset, active high.
REQ-006 req_valid  in  NUM_REQ  per-requester request valid.
REQ-007 req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit high.
REQ-008 req_a, req_b  in  NUM_REQ*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH].
REQ-009 req_op  in  NUM_REQ*2  opcode, requester i at bits [i*2 +: 2].
REQ-010 res_valid  out  1  result valid.
REQ-011 res_ready  in  1  result consumer ready.
REQ-012 res_data  out  WIDTH  result; res_id  out  $clog2(NUM_REQ)  granted requester; res_err  out  1  reserved opcode.
REQ-013 grant_cnt  out  NUM_REQ*8  per-requester grant counters; stats_clr  in  1  synchronous counter clear.

Function
REQ-014 Opcodes: NAND=2'b00, NOR=2'b01, XOR=2'b10 (bitwise on WIDTH bits), 2'b11 reserved.
REQ-015 FSM states are IDLE, EXEC and HOLD.
REQ-016 IDLE: if any req_valid is high, the arbiter SHALL grant one requester round-robin, raise its req_ready for that cycle only, capture a/b/op/id, and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-017 Round-robin: the search SHALL start at last_grant+1 modulo NUM_REQ; after reset, requester 0 has highest priority.
REQ-018 req_ready SHALL be combinational from state and req_valid, and SHALL be high only in IDLE for the granted index.
REQ-019 EXEC: the block SHALL register the gate_unit output into res_data, with res_err set for opcode 2'b11 (res_data=0), and go to HOLD.
REQ-020 HOLD: res_valid SHALL be 1 and res_data/res_id/res_err SHALL be stable; on res_ready=1, the block SHALL return to IDLE with res_valid=0 on the next cycle.
REQ-021 Latency: acceptance at edge T SHALL give res_valid high from T+2; with res_ready held high, throughput SHALL be one operation per 3 cycles.
REQ-022 A requester dropping req_valid while not granted SHALL be ignored, with no state retained for it.
REQ-023 Operands SHALL be sampled only at acceptance; later input changes SHALL not affect the pending result.

Reset
REQ-024 On rst, the block SHALL go to state IDLE, with req_ready=0, res_valid=0, res_data=0, res_id=0, res_err=0, rr pointer giving priority to requester 0, and grant_cnt=0.
REQ-025 rst asserted in EXEC or HOLD SHALL discard the in-flight operation, with no result emitted.
REQ-026 rst SHALL take priority over stats_clr and all handshakes.

Configuration
REQ-027 Macro GATE_OP_ARB_STATS_EN: when defined, each grant_cnt slice SHALL increment on a grant to that requester, saturate at 255, and clear on stats_clr (when a grant and stats_clr coincide, the clear wins).
REQ-028 Without GATE_OP_ARB_STATS_EN: no counter flops; grant_cnt tied to 0 and stats_clr ignored; the port list SHALL be unchanged.

Structure
REQ-029 Package gate_op_pkg SHALL hold the opcode constants/typedef (op_t), the FSM state typedef, and the counter width constant (8).
REQ-030 Sub-module gate_unit (combinational: a, b, op -> y, err) SHALL implement REQ-014; the arbiter SHALL instantiate it exactly once.

Verification
REQ-031 Single request: req0 valid, a=8'hF0, b=8'hCC, op=XOR -> req_ready[0] at T; at T+2, res_valid=1, res_data=8'h3C, res_id=0, res_err=0.
REQ-032 All four valid continuously, res_ready=1, op=NAND, a=b=8'hFF -> grants in order 0,1,2,3,0; each res_data=8'h00; grants 3 cycles apart.
REQ-033 Backpressure: res_ready=0 for 5 cycles in HOLD -> res_valid and res_data held; no req_ready raised; on res_ready=1, back to IDLE next cycle.
REQ-034 Reserved op 2'b11 from req2 -> res_err=1, res_data=0, res_id=2.
REQ-035 rst pulsed in EXEC -> no res_valid afterwards; the next request from req1 and req0 together grants req0 first.
REQ-036 With GATE_OP_ARB_STATS_EN: 300 grants to req1 -> grant_cnt[15:8]=255; stats_clr -> 0 next cycle; without the macro, grant_cnt stays 0.
